// File: rtl/seg7_ctrl_pkg.sv
// Shared types and constants for the three-pair seven-segment display controller.
package seg7_ctrl_pkg;

  localparam int NUM_PAIRS = 3;

  typedef logic [1:0] pair_sel_t;

  localparam pair_sel_t PAIR_ALL = 2'd3;

  typedef enum logic [1:0] {
    LAMP  = 2'd0,
    IDLE  = 2'd1,
    GRANT = 2'd2
  } ctrl_state_e;

  // One bit per display pair touched by a write; PAIR_ALL touches every pair.
  function automatic logic [NUM_PAIRS-1:0] pair_mask(input pair_sel_t sel);
    logic [NUM_PAIRS-1:0] m;
    m = '0;
    if (sel == PAIR_ALL) begin
      m = '1;
    end else begin
      for (int i = 0; i < NUM_PAIRS; i++) begin
        if (sel == pair_sel_t'(i)) m[i] = 1'b1;
      end
    end
    return m;
  endfunction

endpackage

// File: rtl/blink_prescaler.sv
// Free-running divider: phase toggles each time the counter wraps at BLINK_DIV-1.
module blink_prescaler #(
  parameter int BLINK_DIV = 25_000_000
) (
  input  logic clk,
  input  logic reset,
  output logic phase
);

  localparam int CW = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;

  logic [CW-1:0] cnt_q, cnt_d;
  logic          phase_q, phase_d;
  logic          wrap;

  always_comb begin
    wrap    = (cnt_q == CW'(BLINK_DIV - 1));
    cnt_d   = wrap ? '0 : cnt_q + CW'(1);
    phase_d = phase_q ^ wrap;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_q   <= '0;
      phase_q <= 1'b0;
    end else begin
      cnt_q   <= cnt_d;
      phase_q <= phase_d;
    end
  end

  assign phase = phase_q;

endmodule

// File: rtl/seg7_display_ctrl.sv
// Two-requester round-robin write port onto three display pairs, with lamp test and blink.
// Handshake: a requester holds req/pair/data until its one-cycle gnt; inputs are sampled only on the granting edge.
module seg7_display_ctrl
  import seg7_ctrl_pkg::*;
#(
  parameter int LAMP_CYCLES = 50_000_000,
  parameter int BLINK_DIV   = 25_000_000
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic [1:0]                    req,
  input  pair_sel_t                     pair_a,
  input  pair_sel_t                     pair_b,
  input  logic [7:0]                    data_a,
  input  logic [7:0]                    data_b,
  input  logic                          lamp_test,
  input  logic                          blink_en,
  output logic [1:0]                    gnt,
  output logic [NUM_PAIRS-1:0][7:0]     pair_data,
  output logic [NUM_PAIRS-1:0]          pair_blank,
  output logic [NUM_PAIRS-1:0]          pair_test,
  output logic                          busy,
  output ctrl_state_e                   state_o
);

  localparam int LW = (LAMP_CYCLES > 1) ? $clog2(LAMP_CYCLES) : 1;

  ctrl_state_e                 state_q, state_d;
  logic [LW-1:0]               lamp_cnt_q, lamp_cnt_d;
  logic                        prio_b_q, prio_b_d;
  logic [NUM_PAIRS-1:0][7:0]   data_q, data_d;
  logic [NUM_PAIRS-1:0]        valid_q, valid_d;
  logic [1:0]                  gnt_q, gnt_d;
  logic [NUM_PAIRS-1:0]        blank_q, blank_d, test_q, test_d;
  logic                        busy_q, busy_d;
  logic                        phase;
  logic                        win_b;
  pair_sel_t                   wsel;
  logic [7:0]                  wdata;
  logic [NUM_PAIRS-1:0]        wmask;

  blink_prescaler #(.BLINK_DIV(BLINK_DIV)) u_blink (
    .clk   (clk),
    .reset (reset),
    .phase (phase)
  );

  // B wins when it is alone or when the pointer favours it on contention.
  assign win_b = req[1] & (~req[0] | prio_b_q);

  always_comb begin
    state_d    = state_q;
    lamp_cnt_d = lamp_cnt_q;
    prio_b_d   = prio_b_q;
    data_d     = data_q;
    valid_d    = valid_q;
    gnt_d      = 2'b00;
    wsel       = win_b ? pair_b : pair_a;
    wdata      = win_b ? data_b : data_a;
    wmask      = pair_mask(wsel);
    unique case (state_q)
      LAMP: begin
        if (lamp_cnt_q == LW'(LAMP_CYCLES - 1)) begin
          state_d    = IDLE;
          lamp_cnt_d = '0;
        end else begin
          lamp_cnt_d = lamp_cnt_q + LW'(1);
        end
      end
      IDLE: begin
        if (lamp_test) begin
          state_d    = LAMP;
          lamp_cnt_d = '0;
        end else if (|req) begin
          state_d  = GRANT;
          gnt_d    = win_b ? 2'b10 : 2'b01;
          prio_b_d = ~win_b;
          for (int i = 0; i < NUM_PAIRS; i++) begin
            if (wmask[i]) data_d[i] = wdata;
          end
          valid_d = valid_q | wmask;
        end
      end
      GRANT: state_d = IDLE;
      default: state_d = LAMP;
    endcase
    // Outputs are registered from next-state values so they line up with state_q.
    test_d  = (state_d == LAMP) ? '1 : '0;
    blank_d = (state_d == LAMP) ? '0 : (~valid_d | {NUM_PAIRS{blink_en & phase}});
    busy_d  = (state_d != IDLE);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= LAMP;
      lamp_cnt_q <= '0;
      prio_b_q   <= 1'b0;
      data_q     <= '0;
      valid_q    <= '0;
      gnt_q      <= 2'b00;
      blank_q    <= '0;
      test_q     <= '1;
      busy_q     <= 1'b1;
    end else begin
      state_q    <= state_d;
      lamp_cnt_q <= lamp_cnt_d;
      prio_b_q   <= prio_b_d;
      data_q     <= data_d;
      valid_q    <= valid_d;
      gnt_q      <= gnt_d;
      blank_q    <= blank_d;
      test_q     <= test_d;
      busy_q     <= busy_d;
    end
  end

  assign gnt        = gnt_q;
  assign pair_data  = data_q;
  assign pair_blank = blank_q;
  assign pair_test  = test_q;
  assign busy       = busy_q;
  assign state_o    = state_q;

endmodule

// File: tb/tb_seg7_display_ctrl.sv
// Bench for seg7_display_ctrl: directed scenarios then random traffic against a cycle-level reference model.
module tb_seg7_display_ctrl;
  import seg7_ctrl_pkg::*;

  localparam int LAMP_N = 4;
  localparam int DIV_N  = 3;

  // clock/reset block
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic                      reset;
  logic [1:0]                req;
  pair_sel_t                 pair_a, pair_b;
  logic [7:0]                data_a, data_b;
  logic                      lamp_test, blink_en;
  logic [1:0]                gnt;
  logic [NUM_PAIRS-1:0][7:0] pair_data;
  logic [NUM_PAIRS-1:0]      pair_blank, pair_test;
  logic                      busy;
  ctrl_state_e               state_o;

  seg7_display_ctrl #(.LAMP_CYCLES(LAMP_N), .BLINK_DIV(DIV_N)) dut (
    .clk        (clk),
    .reset      (reset),
    .req        (req),
    .pair_a     (pair_a),
    .pair_b     (pair_b),
    .data_a     (data_a),
    .data_b     (data_b),
    .lamp_test  (lamp_test),
    .blink_en   (blink_en),
    .gnt        (gnt),
    .pair_data  (pair_data),
    .pair_blank (pair_blank),
    .pair_test  (pair_test),
    .busy       (busy),
    .state_o    (state_o)
  );

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
  endtask

  // Reference model: what the display should show, tracked from the rules.
  ctrl_state_e m_mode;
  int          m_lamp_left;
  int          m_cyc;
  int          m_last;        // requester granted most recently (0=A, 1=B)
  logic [2:0]  m_valid;
  logic [7:0]  m_data [3];
  logic [1:0]  m_gnt;
  logic [2:0]  m_blank;
  logic [1:0]  exp_q[$];      // scoreboard of expected grants

  task automatic model_edge();
    int   who;
    int   old_phase;
    pair_sel_t sel;
    logic [7:0] d;
    if (reset) begin
      m_mode = LAMP; m_lamp_left = LAMP_N; m_cyc = 0; m_last = 1;
      m_valid = 3'b000; m_gnt = 2'b00; m_blank = 3'b000;
      for (int i = 0; i < 3; i++) m_data[i] = 8'h00;
      return;
    end
    old_phase = (m_cyc / DIV_N) % 2;
    m_cyc++;
    m_gnt = 2'b00;
    case (m_mode)
      LAMP: begin
        m_lamp_left--;
        if (m_lamp_left == 0) m_mode = IDLE;
      end
      GRANT: m_mode = IDLE;
      default: begin
        if (lamp_test) begin
          m_mode = LAMP; m_lamp_left = LAMP_N;
        end else if (req != 2'b00) begin
          if (req == 2'b11) who = 1 - m_last;
          else who = req[1] ? 1 : 0;
          m_last = who;
          sel = who ? pair_b : pair_a;
          d   = who ? data_b : data_a;
          for (int i = 0; i < 3; i++) begin
            if (sel == 2'd3 || int'(sel) == i) begin
              m_data[i] = d; m_valid[i] = 1'b1;
            end
          end
          m_gnt = who ? 2'b10 : 2'b01;
          exp_q.push_back(m_gnt);
          m_mode = GRANT;
        end
      end
    endcase
    if (m_mode == LAMP) m_blank = 3'b000;
    else m_blank = ~m_valid | ((blink_en && old_phase == 1) ? 3'b111 : 3'b000);
  endtask

  task automatic compare_all();
    logic [1:0] e;
    check("gnt",   32'(gnt), 32'(m_gnt));
    check("busy",  32'(busy), 32'(m_mode != IDLE));
    check("test",  32'(pair_test), 32'((m_mode == LAMP) ? 3'b111 : 3'b000));
    check("blank", 32'(pair_blank), 32'(m_blank));
    check("state", 32'(state_o), 32'(m_mode));
    for (int i = 0; i < 3; i++) check($sformatf("data%0d", i), 32'(pair_data[i]), 32'(m_data[i]));
    if (gnt != 2'b00) begin
      check("sb_nonempty", 32'(exp_q.size() > 0), 32'(1));
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        check("sb_grant", 32'(gnt), 32'(e));
      end
    end
  endtask

  // driver tasks
  task automatic tick();
    @(posedge clk);
    model_edge();
    #1;
    compare_all();
  endtask

  task automatic set_a(input logic r, input pair_sel_t p, input logic [7:0] d);
    req[0] = r; pair_a = p; data_a = d;
  endtask

  task automatic set_b(input logic r, input pair_sel_t p, input logic [7:0] d);
    req[1] = r; pair_b = p; data_b = d;
  endtask

  initial begin
    reset = 1'b1; req = 2'b00; pair_a = 2'd0; pair_b = 2'd0;
    data_a = 8'h00; data_b = 8'h00; lamp_test = 1'b0; blink_en = 1'b0;
    tick(); tick();

    // Reset release: four LAMP cycles, then blanked idle
    reset = 1'b0;
    check("rst_test", 32'(pair_test), 32'(3'b111));
    check("rst_busy", 32'(busy), 32'(1));
    check("rst_gnt",  32'(gnt), 32'(0));
    for (int i = 0; i < 3; i++) begin
      tick();
      check("lamp_test_hold", 32'(pair_test), 32'(3'b111));
    end
    tick();
    check("idle_test",  32'(pair_test), 32'(3'b000));
    check("idle_blank", 32'(pair_blank), 32'(3'b111));
    check("idle_busy",  32'(busy), 32'(0));

    // Contention: A, B, A with both requests held
    set_a(1'b1, 2'd0, 8'h11); set_b(1'b1, 2'd2, 8'h22);
    tick(); check("rr1", 32'(gnt), 32'(2'b01));
    tick(); check("rr_gap1", 32'(gnt), 32'(2'b00));
    tick(); check("rr2", 32'(gnt), 32'(2'b10));
    tick(); check("rr_gap2", 32'(gnt), 32'(2'b00));
    tick(); check("rr3", 32'(gnt), 32'(2'b01));
    req = 2'b00;
    tick();

    // Single write to middle pair
    set_a(1'b1, 2'd1, 8'hA5);
    tick();
    check("wr_gnt",   32'(gnt), 32'(2'b01));
    check("wr_data",  32'(pair_data[1]), 32'(8'hA5));
    check("wr_blank", 32'(pair_blank), 32'(3'b000));
    check("wr_busy",  32'(busy), 32'(1));
    req = 2'b00;
    tick();

    // Broadcast from B, then blink
    set_b(1'b1, 2'd3, 8'h3C);
    tick();
    check("bc_gnt", 32'(gnt), 32'(2'b10));
    for (int i = 0; i < 3; i++) check("bc_data", 32'(pair_data[i]), 32'(8'h3C));
    check("bc_blank", 32'(pair_blank), 32'(3'b000));
    req = 2'b00;
    blink_en = 1'b1;
    for (int i = 0; i < 14; i++) tick();
    blink_en = 1'b0;
    tick();

    // Lamp test beats a simultaneous request; request waits out the lamp phase
    lamp_test = 1'b1; set_a(1'b1, 2'd0, 8'h5A);
    tick();
    lamp_test = 1'b0;
    check("lt_gnt", 32'(gnt), 32'(2'b00));
    for (int i = 0; i < 3; i++) begin
      tick();
      check("lt_hold_gnt", 32'(gnt), 32'(2'b00));
    end
    tick();
    tick();
    check("lt_after_gnt", 32'(gnt), 32'(2'b01));
    req = 2'b00;
    tick();

    // Reset during GRANT
    set_b(1'b1, 2'd0, 8'h77);
    tick();
    check("pre_rst_gnt", 32'(gnt), 32'(2'b10));
    req = 2'b00; reset = 1'b1;
    tick();
    reset = 1'b0;
    for (int i = 0; i < 3; i++) check("rst_data", 32'(pair_data[i]), 32'(8'h00));
    check("rst_state", 32'(state_o), 32'(LAMP));
    for (int i = 0; i < 6; i++) tick();

    // Random traffic obeying the hold-until-grant rule
    for (int n = 0; n < 800; n++) begin
      reset     = ($urandom_range(0, 199) == 0);
      lamp_test = ($urandom_range(0, 59) == 0);
      if ($urandom_range(0, 19) == 0) blink_en = ~blink_en;
      for (int r = 0; r < 2; r++) begin
        if (reset || (req[r] && gnt[r])) begin
          req[r] = 1'b0;
        end else if (!req[r] && $urandom_range(0, 2) == 0) begin
          if (r == 0) set_a(1'b1, pair_sel_t'($urandom_range(0, 3)), 8'($urandom_range(0, 255)));
          else        set_b(1'b1, pair_sel_t'($urandom_range(0, 3)), 8'($urandom_range(0, 255)));
        end
      end
      tick();
    end

    check("sb_drained", 32'(exp_q.size()), 32'(0));
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/seg7_display_ctrl.md
SEG7_DISPLAY_CTRL -- requirements
Module: seg7_display_ctrl

Interface
REQ-001 Parameter LAMP_CYCLES, default 50_000_000: number of clocks the lamp-test phase lasts.
REQ-002 Parameter BLINK_DIV, default 25_000_000: clocks per blink half-period.
REQ-003 clk  input  1  single system clock; all state updates on the rising edge.
REQ-004 reset  input  1  synchronous, active-high reset.
REQ-005 req  input  2  write request per requester; bit 0 = requester A, bit 1 = requester B.
REQ-006 pair_a, pair_b  input  2 each  target display pair: 0 = right, 1 = middle, 2 = left, 3 = broadcast to all three.
REQ-007 data_a, data_b  input  8 each  byte to show on the target pair.
REQ-008 lamp_test  input  1  request for a lamp-test phase.
REQ-009 blink_en  input  1  when high, written pairs blink.
REQ-010 gnt  output  2  one-hot, one-cycle grant per requester.
REQ-011 pair_data  output  3x8  byte presented to the data input of each dual seven-segment decoder.
REQ-012 pair_blank, pair_test  output  3 each  blank and test controls per pair.
REQ-013 busy  output  1  high whenever the state is not IDLE.

Function
REQ-014 The FSM SHALL have states LAMP, IDLE and GRANT.
- LAMP: all pair_test = 1, all pair_blank = 0, and no grants.
- LAMP lasts exactly LAMP_CYCLES clocks, then goes to IDLE.
REQ-015 In IDLE with any req bit high, the winner SHALL be chosen on the next edge, with these effects on that same edge:
- gnt bit of the winner goes high.
- pair_data of the target pair(s) loads the winner's data.
- The target pair(s) become valid.
- The FSM moves to GRANT.
REQ-016 GRANT SHALL last one cycle with gnt = 0, then return to IDLE, so a write completes at most once every 2 cycles.
REQ-017 A requester SHALL hold req, pair and data stable until it sees its gnt; the controller samples them only on the edge that raises gnt.
REQ-018 Arbitration SHALL be round-robin:
- A single requester always wins.
- On contention, the requester not granted most recently wins.
- The priority pointer resets to A.
REQ-019 A broadcast write (pair = 3) SHALL load all three pair_data registers and set all three valid bits on the same edge.
REQ-020 lamp_test sampled high in IDLE SHALL move the FSM to LAMP on the next edge. It takes precedence over a simultaneous req, which is not granted. lamp_test is ignored in GRANT and in LAMP.
REQ-021 Requests raised during LAMP or GRANT SHALL remain pending and are arbitrated on the first IDLE cycle.
REQ-022 The blink prescaler behaves as follows:
- A counter runs 0..BLINK_DIV-1 continuously in all states.
- The blink phase toggles on each wrap.
- blink_en does not reset the counter.
REQ-023 Outside LAMP, pair_blank[i] SHALL equal (not valid[i]) or (blink_en and phase).
REQ-024 Outside LAMP, pair_test SHALL be 0.
REQ-025 pair_data, pair_blank and pair_test SHALL be registered outputs. gnt and busy SHALL also be registered.

Reset
REQ-026 Reset SHALL have priority over all other inputs and SHALL abort any state, including mid-LAMP and GRANT. It sets:
- state = LAMP with the lamp counter at 0
- gnt = 0
- all pair_data = 8'h00
- all valid bits = 0
- priority pointer = A
- blink counter = 0 and phase = 0
REQ-027 In the first cycle after reset deasserts, outputs SHALL be: pair_test = 3'b111, pair_blank = 3'b000, busy = 1, gnt = 2'b00.

Structure
REQ-028 A shared package seg7_ctrl_pkg SHALL hold:
- the state enum (LAMP, IDLE, GRANT)
- NUM_PAIRS = 3
- the 2-bit pair-select type
- the constant PAIR_ALL = 3
REQ-029 The blink counter/phase SHALL be the sub-module blink_prescaler (parameter BLINK_DIV, ports clk, reset, phase). Arbitration and the FSM stay in the top module.
REQ-030 The three pair outputs SHALL connect one-to-one to three dual seven-segment decoder instances at board level.

Verification (LAMP_CYCLES = 4, BLINK_DIV = 3)
REQ-031 Reset release: pair_test = 111 and busy = 1 for exactly 4 cycles, then pair_test = 000, pair_blank = 111 and busy = 0.
REQ-032 Single write: req = 01, pair_a = 1, data_a = 8'hA5 in IDLE. gnt = 01 for one cycle, pair_data[1] = A5, and pair_blank = 101 on that edge. busy = 1 during GRANT.
REQ-033 Contention: req = 11 held for both requesters. Grants go A, then B, then A, each separated by one GRANT cycle.
REQ-034 Broadcast: pair_b = 3, data_b = 8'h3C. All pair_data = 3C and pair_blank = 000. Then blink_en = 1 gives pair_blank toggling 000/111 every 3 cycles.
REQ-035 Simultaneous events: lamp_test = 1 and req = 01 in the same IDLE cycle. LAMP runs 4 cycles with gnt = 00, then gnt = 01 on the first IDLE cycle.
REQ-036 Reset mid-operation: reset asserted during GRANT after a write. All pair_data = 00, valid bits cleared, and the FSM returns to LAMP.
